// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard scan-code decoder.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_e;

  // rel is the break (key released) flag; "release" is a reserved word
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_event_t;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_ERR_00     = 8'h00;
  localparam logic [7:0] PS2_ERR_FF     = 8'hFF;

  function automatic logic is_kbd_err_code(input logic [7:0] b);
    return (b == PS2_ERR_00) || (b == PS2_ERR_FF);
  endfunction

  function automatic kbd_event_t make_event(input logic ext, input logic rel,
                                            input logic [7:0] code);
    kbd_event_t ev;
    ev.ext  = ext;
    ev.rel  = rel;
    ev.code = code;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_kbd_decoder_fifo.sv
// ps2_kbd_fifo: first-word-fall-through FIFO; the head entry is always on rd_data.
// A pop on an empty FIFO is ignored; a write on a full FIFO only lands if a pop
// happens in the same cycle.
module ps2_kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so rd_data reads 0 after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: turns PS/2 scan-code set 2 bytes into key events queued in a FIFO.
// Optional feature: define PS2_KBD_ERR_CNT_EN to build the saturating parity-error
// counter; otherwise err_cnt reads 0 and error bytes are only discarded.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             ps2_byte,
  input  logic                   ps2_valid,
  input  logic                   ps2_err,
  input  logic                   rd_en,
  input  logic                   clr,
  output logic [9:0]             rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             err_cnt
);

  logic       sync1, sync2, sync3;
  logic [1:0] warm;
  logic       armed;
  logic       byte_stb;
  kbd_state_e state;
  logic       emit_vld;
  kbd_event_t emit_evt;
  logic       fifo_full;
  logic       ovf_evt;

  // Synchronize ps2_valid; "armed" waits until the synced level has been seen low
  // after reset so a valid held high across reset cannot fake a strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= ps2_valid;
      sync2 <= sync1;
      sync3 <= sync2;
      warm  <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & ~sync2);
    end
  end

  assign byte_stb = sync2 & ~sync3 & armed;

  // Prefix-tracking decoder; completed events are registered for the FIFO write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      emit_vld <= 1'b0;
      emit_evt <= '0;
    end else begin
      emit_vld <= 1'b0;
      if (byte_stb) begin
        if (ps2_err || is_kbd_err_code(ps2_byte)) begin
          state <= IDLE;
        end else begin
          case (state)
            IDLE: begin
              if (ps2_byte == PS2_EXT_PREFIX)      state <= EXT;
              else if (ps2_byte == PS2_BRK_PREFIX) state <= BRK;
              else begin
                emit_vld <= 1'b1;
                emit_evt <= make_event(1'b0, 1'b0, ps2_byte);
              end
            end
            EXT: begin
              if (ps2_byte == PS2_BRK_PREFIX)      state <= EXT_BRK;
              else if (ps2_byte == PS2_EXT_PREFIX) state <= EXT;
              else begin
                emit_vld <= 1'b1;
                emit_evt <= make_event(1'b1, 1'b0, ps2_byte);
                state    <= IDLE;
              end
            end
            BRK: begin
              if (ps2_byte != PS2_EXT_PREFIX && ps2_byte != PS2_BRK_PREFIX) begin
                emit_vld <= 1'b1;
                emit_evt <= make_event(1'b0, 1'b1, ps2_byte);
              end
              state <= IDLE;
            end
            EXT_BRK: begin
              if (ps2_byte != PS2_EXT_PREFIX && ps2_byte != PS2_BRK_PREFIX) begin
                emit_vld <= 1'b1;
                emit_evt <= make_event(1'b1, 1'b1, ps2_byte);
              end
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  ps2_kbd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(kbd_event_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (emit_vld),
    .wr_data(emit_evt),
    .rd_en  (rd_en),
    .rd_data(rd_data),
    .count  (count),
    .full   (fifo_full),
    .empty  (empty)
  );

  // A full FIFO only drops the event when no pop frees a slot in the same cycle
  assign ovf_evt = emit_vld & fifo_full & ~rd_en;

  // Sticky overflow flag; a new drop takes priority over clr
  always_ff @(posedge clk) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_evt) overflow <= 1'b1;
    else if (clr)     overflow <= 1'b0;
  end

`ifdef PS2_KBD_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating parity-error counter; an increment takes priority over clr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (byte_stb && ps2_err) begin
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end else if (clr) begin
      err_cnt_q <= 8'd0;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Self-checking bench for ps2_kbd_decoder: a rule-level decoder/queue model plus
// hand-computed literal expectations. Honours PS2_KBD_ERR_CNT_EN if defined.
module tb_ps2_kbd_decoder;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    ps2_byte = 8'h00;
  logic          ps2_valid = 1'b0;
  logic          ps2_err = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr = 1'b0;
  logic [9:0]    rd_data;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    err_cnt;

  int checks   = 0;
  int failures = 0;
  bit settled  = 1'b0;

  logic [9:0] exp_q[$];
  bit         model_ovf;
  int         model_err;
  bit         ext_pending;
  bit         brk_pending;

  ps2_kbd_decoder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_byte (ps2_byte),
    .ps2_valid(ps2_valid),
    .ps2_err  (ps2_err),
    .rd_en    (rd_en),
    .clr      (clr),
    .rd_data  (rd_data),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic int expErr();
`ifdef PS2_KBD_ERR_CNT_EN
    return model_err;
`else
    return 0;
`endif
  endfunction

  task automatic modelReset();
    exp_q.delete();
    model_ovf   = 1'b0;
    model_err   = 0;
    ext_pending = 1'b0;
    brk_pending = 1'b0;
  endtask

  // Scan-code set 2 rules: prefixes accumulate, anything else completes an event
  task automatic modelByte(input logic [7:0] b, input logic e);
    if (e) begin
      ext_pending = 1'b0;
      brk_pending = 1'b0;
      if (model_err < 255) model_err++;
    end else if (b == 8'h00 || b == 8'hFF) begin
      ext_pending = 1'b0;
      brk_pending = 1'b0;
    end else if (b == 8'hE0 || b == 8'hF0) begin
      if (brk_pending) begin
        ext_pending = 1'b0;
        brk_pending = 1'b0;
      end else if (b == 8'hE0) begin
        ext_pending = 1'b1;
      end else begin
        brk_pending = 1'b1;
      end
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({ext_pending, brk_pending, b});
      else model_ovf = 1'b1;
      ext_pending = 1'b0;
      brk_pending = 1'b0;
    end
  endtask

  // Continuous comparison against the model whenever no byte is in flight
  always @(negedge clk) begin
    if (settled && rst_n) begin
      checkOutput("cyc_count", int'(count), exp_q.size());
      checkOutput("cyc_empty", int'(empty), (exp_q.size() == 0) ? 1 : 0);
      checkOutput("cyc_overflow", int'(overflow), int'(model_ovf));
      checkOutput("cyc_err_cnt", int'(err_cnt), expErr());
      if (exp_q.size() != 0) checkOutput("cyc_rd_data", int'(rd_data), int'(exp_q[0]));
    end
  end

  task automatic doReset();
    settled = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    modelReset();
    repeat (5) @(posedge clk);
    #1 settled = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic e);
    settled = 1'b0;
    @(posedge clk); #1;
    ps2_byte  = b;
    ps2_err   = e;
    ps2_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 ps2_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    modelByte(b, e);
    settled = 1'b1;
  endtask

  task automatic popEvent();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic clearFlags();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    model_ovf = 1'b0;
    model_err = 0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    logic [7:0] seq_mb  [3] = '{8'h1C, 8'hF0, 8'h1C};
    logic [7:0] seq_ext [8] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'hE0, 8'h6C};
    logic [7:0] seq_mal [7] = '{8'hF0, 8'hF0, 8'h1C, 8'h00, 8'hE0, 8'hFF, 8'h1C};

    $display("[TB] starting ps2_kbd_decoder bench");
    modelReset();
    doReset();
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_err_cnt", int'(err_cnt), 0);
    checkOutput("rst_rd_data", int'(rd_data), 10'h000);

    // Make then break of the same key
    foreach (seq_mb[i]) applyStimulus(seq_mb[i], 1'b0);
    checkOutput("mb_count", int'(count), 2);
    checkOutput("mb_first", int'(rd_data), 10'h01C);
    popEvent();
    checkOutput("mb_second", int'(rd_data), 10'h11C);
    popEvent();
    checkOutput("mb_empty", int'(empty), 1);

    // Extended make, extended break, repeated E0 prefix
    foreach (seq_ext[i]) applyStimulus(seq_ext[i], 1'b0);
    checkOutput("ext_count", int'(count), 3);
    checkOutput("ext_make", int'(rd_data), 10'h275);
    popEvent();
    checkOutput("ext_break", int'(rd_data), 10'h375);
    popEvent();
    checkOutput("ext_double_e0", int'(rd_data), 10'h26C);
    popEvent();

    // Parity error after an E0 prefix drops the byte and returns to idle
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h6B, 1'b1);
    applyStimulus(8'h6B, 1'b0);
    checkOutput("par_count", int'(count), 1);
    checkOutput("par_event", int'(rd_data), 10'h06B);
`ifdef PS2_KBD_ERR_CNT_EN
    checkOutput("par_err_cnt", int'(err_cnt), 1);
`else
    checkOutput("par_err_cnt", int'(err_cnt), 0);
`endif
    popEvent();
    clearFlags();
    checkOutput("par_err_clr", int'(err_cnt), 0);

    // Malformed prefixes and keyboard error codes
    foreach (seq_mal[i]) applyStimulus(seq_mal[i], 1'b0);
    checkOutput("mal_count", int'(count), 2);
    checkOutput("mal_first", int'(rd_data), 10'h01C);
    popEvent();
    checkOutput("mal_second", int'(rd_data), 10'h01C);
    popEvent();

    // Reset after an F0 prefix with valid held high across the reset
    settled = 1'b0;
    @(posedge clk); #1;
    ps2_byte  = 8'hF0;
    ps2_err   = 1'b0;
    ps2_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    modelReset();
    repeat (8) @(posedge clk);
    #1 ps2_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 settled = 1'b1;
    checkOutput("rmid_no_strobe", int'(empty), 1);
    applyStimulus(8'h2D, 1'b0);
    checkOutput("rmid_count", int'(count), 1);
    checkOutput("rmid_event", int'(rd_data), 10'h02D);
    popEvent();

    // Overflow: DEPTH+1 makes, the last one is lost
    for (int i = 0; i <= DEPTH; i++) applyStimulus(8'h10 + 8'(i), 1'b0);
    checkOutput("ovf_count", int'(count), DEPTH);
    checkOutput("ovf_flag", int'(overflow), 1);
    checkOutput("ovf_head", int'(rd_data), 10'h010);
    clearFlags();
    checkOutput("ovf_clr", int'(overflow), 0);

    // Write and pop in the same cycle while full: event lands at index 4 edges later
    settled = 1'b0;
    @(posedge clk); #1;
    ps2_byte  = 8'h20;
    ps2_err   = 1'b0;
    ps2_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    void'(exp_q.pop_front());
    exp_q.push_back(10'h020);
    settled = 1'b1;
    checkOutput("wp_count", int'(count), DEPTH);
    checkOutput("wp_overflow", int'(overflow), 0);
    checkOutput("wp_head", int'(rd_data), 10'h011);
    for (int i = 0; i < DEPTH - 1; i++) popEvent();
    checkOutput("wp_tail", int'(rd_data), 10'h020);
    popEvent();
    checkOutput("wp_drained", int'(empty), 1);

    repeat (3) @(posedge clk);
    settled = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
